// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: register-file geometry, the late-result
// buffer entry, the write-port selection code and a register-mask helper.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  localparam reg_addr_t X0 = 5'd0;

  // One buffered late result waiting for the write port
  typedef struct packed {
    reg_addr_t waddr;
    xlen_t     wd;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_BUF  = 2'd2
  } wr_sel_e;

  // One-hot mask for register r; x0 never produces a bit
  function automatic reg_mask_t reg_mask(input reg_addr_t r);
    reg_mask_t m;
    m = {NUM_REGS{1'b0}};
    if (r != X0) begin
      m[r] = 1'b1;
    end else begin
      m = {NUM_REGS{1'b0}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Late-result buffer: small FIFO of {waddr, wd}. Pointers carry one extra
// wrap bit so full and empty are told apart without an occupancy counter.
// Full is computed from the registered pointers only, so a pop in the same
// cycle never frees room for a push (no pop-through).
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_entry_t   mem_r [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  // Guard against overflow/underflow regardless of what the caller drives
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Pointer update; reset discards any buffered content
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The WB stage always wins the port
// because it cannot be stalled; late mul/div results wait in wb_fifo and
// drain whenever WB has nothing live to write. A scoreboard marks
// destinations whose late result is still outstanding so ID can stall, and
// a starvation counter asks ID for a bubble when the buffer is locked out.
module rf_write_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wd,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_waddr,
  input  logic [XLEN-1:0]       md_wd,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_issue_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  hazard,
  output logic                  drain_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wd,
  output logic [NUM_REGS-1:0]   pending
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic      live_s;
  logic      pop_s;
  logic      push_s;
  logic      full_s;
  logic      empty_s;
  wb_entry_t head_s;
  wb_entry_t din_s;
  wr_sel_e   sel_s;
  reg_mask_t set_mask_s;
  reg_mask_t clr_mask_s;
  reg_mask_t pending_nxt_s;
  reg_mask_t pending_r;
  logic [3:0] cnt_nxt_s;
  logic [3:0] cnt_r;

  assign din_s = '{waddr: md_waddr, wd: md_wd};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Port arbitration: live WB write first, else drain the buffer head
  always_comb begin
    live_s   = rst & pipe_we & (pipe_waddr != X0);
    pop_s    = rst & ~empty_s & ~live_s;
    md_ready = rst & ~full_s;
    push_s   = md_valid & md_ready;
    if (live_s) begin
      sel_s = SEL_PIPE;
    end else if (pop_s) begin
      sel_s = SEL_BUF;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Drive the register file; idle port shows all-zero address and data
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = X0;
    rf_wd    = {XLEN{1'b0}};
    case (sel_s)
      SEL_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wd    = pipe_wd;
      end
      SEL_BUF: begin
        // x0 results still pop but never reach the register file
        if (head_s.waddr != X0) begin
          rf_we    = 1'b1;
          rf_waddr = head_s.waddr;
          rf_wd    = head_s.wd;
        end else begin
          rf_we    = 1'b0;
          rf_waddr = X0;
          rf_wd    = {XLEN{1'b0}};
        end
      end
      SEL_NONE: begin
        rf_we    = 1'b0;
        rf_waddr = X0;
        rf_wd    = {XLEN{1'b0}};
      end
      default: begin
        rf_we    = 1'b0;
        rf_waddr = X0;
        rf_wd    = {XLEN{1'b0}};
      end
    endcase
  end

  // Scoreboard next state: a same-cycle issue overrides the clear so a
  // reissued destination stays pending for its newer result
  always_comb begin
    if (md_issue) begin
      set_mask_s = reg_mask(md_issue_rd);
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (pop_s) begin
      clr_mask_s = reg_mask(head_s.waddr);
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign pending = pending_r;

  // ID stall on any source or destination with an outstanding late result
  always_comb begin
    hazard = rst & id_valid &
             (pending_r[id_rs1] | pending_r[id_rs2] | pending_r[id_rd]);
  end

  // Starvation counter next state: counts blocked cycles, saturates, any pop clears
  always_comb begin
    if (pop_s) begin
      cnt_nxt_s = 4'd0;
    end else if (~empty_s & live_s) begin
      if (cnt_r != LIMIT) begin
        cnt_nxt_s = cnt_r + 4'd1;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign drain_req = (cnt_r == LIMIT);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter. Stimulus pushes every register-file
// write it expects into a queue; a negedge monitor pops and compares each
// write the DUT presents. Status outputs are compared inline.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_waddr;
  logic [31:0] md_wd;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        hazard;
  logic        drain_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;
  logic [31:0] pending;

  int n_cmp;
  int n_fail;
  logic [36:0] exp_q[$];

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wd(pipe_wd),
    .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wd(md_wd),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .hazard(hazard), .drain_req(drain_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic clear_inputs();
    pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wd = 32'd0;
    md_valid = 1'b0; md_waddr = 5'd0; md_wd = 32'd0;
    md_issue = 1'b0; md_issue_rd = 5'd0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_we = 1'b1; pipe_waddr = a; pipe_wd = d;
  endtask

  task automatic drive_md(input logic [4:0] a, input logic [31:0] d);
    md_valid = 1'b1; md_waddr = a; md_wd = d;
  endtask

  // Write monitor: every presented write must match the oldest expectation
  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", rf_waddr, rf_wd);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wd} !== e) begin
          n_fail++;
          $display("FAIL rf_write: got x%0d=%h expected x%0d=%h", rf_waddr, rf_wd, e[36:32], e[31:0]);
        end
      end
    end else if (rf_waddr !== 5'd0 || rf_wd !== 32'd0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_port: got x%0d=%h expected x0=0", rf_waddr, rf_wd);
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clear_inputs();
    rst = 1'b0;

    // Reset and idle
    step();
    #2 check("md_ready_in_reset", {31'd0, md_ready}, 32'd0);
    step();
    rst = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6; id_rd = 5'd7;
    #2;
    check("md_ready_idle", {31'd0, md_ready}, 32'd1);
    check("pending_idle", pending, 32'd0);
    check("hazard_idle", {31'd0, hazard}, 32'd0);
    check("drain_idle", {31'd0, drain_req}, 32'd0);
    step();
    clear_inputs();

    // Issue x5, then late result, then scoreboard clears
    md_issue = 1'b1; md_issue_rd = 5'd5;
    step();
    clear_inputs();
    id_valid = 1'b1; id_rs2 = 5'd5;
    drive_md(5'd5, 32'hDEADBEEF);
    #2;
    check("pend5_set", {31'd0, pending[5]}, 32'd1);
    check("hazard_rs2_5", {31'd0, hazard}, 32'd1);
    step();
    md_valid = 1'b0;
    expect_wr(5'd5, 32'hDEADBEEF);
    #2 check("hazard_during_wr", {31'd0, hazard}, 32'd1);
    step();
    #2;
    check("pend5_clear", {31'd0, pending[5]}, 32'd0);
    check("hazard_drop", {31'd0, hazard}, 32'd0);
    clear_inputs();
    step();

    // Starvation: WB writes x3 every cycle while two late results wait
    drive_pipe(5'd3, 32'h11); drive_md(5'd7, 32'h77); expect_wr(5'd3, 32'h11);
    step();
    drive_md(5'd8, 32'h88); expect_wr(5'd3, 32'h11);
    #2 check("md_ready_one_entry", {31'd0, md_ready}, 32'd1);
    step();
    drive_md(5'd9, 32'h99); expect_wr(5'd3, 32'h11);
    #2 check("md_ready_full", {31'd0, md_ready}, 32'd0);
    step();
    md_valid = 1'b0; expect_wr(5'd3, 32'h11);
    step();
    expect_wr(5'd3, 32'h11);
    #2 check("drain_after_3", {31'd0, drain_req}, 32'd0);
    step();
    expect_wr(5'd3, 32'h11);
    #2 check("drain_after_4", {31'd0, drain_req}, 32'd1);
    step();
    pipe_we = 1'b0; expect_wr(5'd7, 32'h77);
    #2 check("drain_in_bubble", {31'd0, drain_req}, 32'd1);
    step();
    expect_wr(5'd8, 32'h88);
    #2 check("drain_after_pop", {31'd0, drain_req}, 32'd0);
    step();
    clear_inputs();
    step();

    // x0 results and x0 pipe writes never write, but x0 entry still pops
    drive_md(5'd0, 32'hABC); drive_pipe(5'd0, 32'h55);
    step();
    drive_pipe(5'd3, 32'h12); expect_wr(5'd3, 32'h12); drive_md(5'd10, 32'hA0);
    #2 check("md_ready_x0_entry", {31'd0, md_ready}, 32'd1);
    step();
    md_valid = 1'b0; drive_pipe(5'd0, 32'h56);
    #2 check("md_ready_full_x0", {31'd0, md_ready}, 32'd0);
    step();
    pipe_we = 1'b0; expect_wr(5'd10, 32'hA0);
    #2 check("md_ready_after_x0_pop", {31'd0, md_ready}, 32'd1);
    step();
    clear_inputs();

    // Reissue of x9 in the same cycle its old result commits keeps it pending
    md_issue = 1'b1; md_issue_rd = 5'd9; drive_md(5'd9, 32'h9999);
    step();
    md_valid = 1'b0; expect_wr(5'd9, 32'h9999);
    step();
    md_issue = 1'b0; drive_md(5'd9, 32'h1);
    #2 check("pend9_set_wins", {31'd0, pending[9]}, 32'd1);
    step();
    md_valid = 1'b0; expect_wr(5'd9, 32'h1);
    step();
    #2 check("pend9_final_clear", {31'd0, pending[9]}, 32'd0);

    // Reset with two buffered results discards them
    md_issue = 1'b1; md_issue_rd = 5'd4; drive_pipe(5'd3, 32'h33); drive_md(5'd4, 32'h44);
    expect_wr(5'd3, 32'h33);
    step();
    md_issue_rd = 5'd6; drive_pipe(5'd3, 32'h34); drive_md(5'd6, 32'h66);
    expect_wr(5'd3, 32'h34);
    step();
    clear_inputs();
    rst = 1'b0;
    #2;
    check("pending_before_rst", pending, 32'h0000_0050);
    check("md_ready_mid_rst", {31'd0, md_ready}, 32'd0);
    step();
    rst = 1'b1;
    #2;
    check("pending_after_rst", pending, 32'd0);
    check("md_ready_after_rst", {31'd0, md_ready}, 32'd1);
    check("drain_after_rst", {31'd0, drain_req}, 32'd0);
    step();
    step();
    step();

    check("exp_queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
